macc_pipe: RTL and testbench

- Parametrised successor to the fixed 25x18 registered multiply + carry-in block.
- Configurable operand and result widths, signed or unsigned arithmetic, and a configurable multiplier pipeline depth.
- Adds valid tracking, a per-beat accumulate/load mode, a pipeline-wide clock enable and a sticky overflow flag.
- Used as the generic MAC primitive for DSP-inference tests and filter datapaths.

---
 rtl/macc_pipe.sv | 157 +++++++++++++++
 tb/tb_macc_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/macc_pipe.sv
// macc_pipe: pipelined multiply-accumulate with carry-in, per-beat load or accumulate,
// a clock enable that freezes every register, and a sticky overflow flag.
module macc_pipe #(
  parameter int A_WIDTH    = 25,
  parameter int B_WIDTH    = 18,
  parameter int P_WIDTH    = 48,
  parameter bit SIGNED     = 1'b0,
  parameter int MUL_STAGES = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic               IN_VALID,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  input  logic               CARRYIN,
  input  logic               ACC,
  output logic [P_WIDTH-1:0] P,
  output logic               OUT_VALID,
  output logic               OVF
);
  localparam int M_WIDTH = A_WIDTH + B_WIDTH;

  if (M_WIDTH > P_WIDTH) begin : g_bad_width
    $error("macc_pipe: A_WIDTH+B_WIDTH must not exceed P_WIDTH");
  end
  if (MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_bad_stages
    $error("macc_pipe: MUL_STAGES must be in 1..4");
  end

  logic [A_WIDTH-1:0] a_q;
  logic [B_WIDTH-1:0] b_q;
  logic               in_vld_q;
  logic               in_cin_q;
  logic               in_acc_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      a_q      <= '0;
      b_q      <= '0;
      in_vld_q <= 1'b0;
      in_cin_q <= 1'b0;
      in_acc_q <= 1'b0;
    end else if (CE) begin
      a_q      <= A;
      b_q      <= B;
      in_vld_q <= IN_VALID;
      in_cin_q <= CARRYIN;
      in_acc_q <= ACC;
    end
  end

  // Low M_WIDTH bits of the product of extended operands are exact for either signedness.
  logic [M_WIDTH-1:0] a_ext;
  logic [M_WIDTH-1:0] b_ext;
  logic [M_WIDTH-1:0] prod_full;
  logic [P_WIDTH-1:0] prod_ext;

  assign a_ext     = {{B_WIDTH{SIGNED & a_q[A_WIDTH-1]}}, a_q};
  assign b_ext     = {{A_WIDTH{SIGNED & b_q[B_WIDTH-1]}}, b_q};
  assign prod_full = a_ext * b_ext;
  assign prod_ext  = SIGNED ? P_WIDTH'($signed(prod_full)) : P_WIDTH'(prod_full);

  for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_stage
    logic [P_WIDTH-1:0] prod_d;
    logic               vld_d;
    logic               cin_d;
    logic               acc_d;
    logic [P_WIDTH-1:0] prod_q;
    logic               vld_q;
    logic               cin_q;
    logic               acc_q;

    if (gi == 0) begin : g_first
      assign prod_d = prod_ext;
      assign vld_d  = in_vld_q;
      assign cin_d  = in_cin_q;
      assign acc_d  = in_acc_q;
    end else begin : g_chain
      assign prod_d = g_stage[gi-1].prod_q;
      assign vld_d  = g_stage[gi-1].vld_q;
      assign cin_d  = g_stage[gi-1].cin_q;
      assign acc_d  = g_stage[gi-1].acc_q;
    end

    always_ff @(posedge CLK) begin
      if (!RST) begin
        prod_q <= '0;
        vld_q  <= 1'b0;
        cin_q  <= 1'b0;
        acc_q  <= 1'b0;
      end else if (CE) begin
        prod_q <= prod_d;
        vld_q  <= vld_d;
        cin_q  <= cin_d;
        acc_q  <= acc_d;
      end
    end
  end

  logic [P_WIDTH-1:0] last_prod;
  logic               last_vld;
  logic               last_cin;
  logic               last_acc;

  assign last_prod = g_stage[MUL_STAGES-1].prod_q;
  assign last_vld  = g_stage[MUL_STAGES-1].vld_q;
  assign last_cin  = g_stage[MUL_STAGES-1].cin_q;
  assign last_acc  = g_stage[MUL_STAGES-1].acc_q;

  logic [P_WIDTH-1:0] p_q;
  logic [P_WIDTH-1:0] p_d;
  logic               ovf_q;
  logic               ovf_d;
  logic               out_vld_q;
  logic               out_vld_d;
  logic [P_WIDTH:0]   acc_sum;
  logic               ovf_beat;

  // One extra bit: carry for unsigned, a guard sign bit for signed.
  assign acc_sum  = {SIGNED & p_q[P_WIDTH-1], p_q}
                  + {SIGNED & last_prod[P_WIDTH-1], last_prod}
                  + (P_WIDTH+1)'(last_cin);
  assign ovf_beat = SIGNED ? (acc_sum[P_WIDTH] ^ acc_sum[P_WIDTH-1]) : acc_sum[P_WIDTH];

  always_comb begin
    p_d       = p_q;
    ovf_d     = ovf_q;
    out_vld_d = 1'b0;
    if (last_vld) begin
      out_vld_d = 1'b1;
      if (last_acc) begin
        p_d   = acc_sum[P_WIDTH-1:0];
        ovf_d = ovf_q | ovf_beat;
      end else begin
        p_d   = last_prod + P_WIDTH'(last_cin);
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      p_q       <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (CE) begin
      p_q       <= p_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign P         = p_q;
  assign OVF       = ovf_q;
  assign OUT_VALID = out_vld_q;
endmodule

// File: tb/tb_macc_pipe.sv
// tb_macc_pipe: three macc_pipe configurations checked every cycle against an
// issue-order arithmetic model delayed by the latency, plus literal expectations.
module tb_macc_pipe;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;
  logic ce [3];
  logic iv [3];
  logic cin [3];
  logic acc [3];
  logic ov [3];
  logic ovf [3];
  logic [24:0] a0;
  logic [17:0] b0;
  logic [47:0] p0;
  logic [7:0]  a1, b1, a2, b2;
  logic [15:0] p1, p2;

  localparam int AW  [3] = '{25, 8, 8};
  localparam int BW  [3] = '{18, 8, 8};
  localparam int PW  [3] = '{48, 16, 16};
  localparam int SG  [3] = '{0, 1, 0};
  localparam int LAT [3] = '{2, 4, 3};

  macc_pipe u_dut0 (
    .CLK(CLK), .RST(RST), .CE(ce[0]), .IN_VALID(iv[0]), .A(a0), .B(b0),
    .CARRYIN(cin[0]), .ACC(acc[0]), .P(p0), .OUT_VALID(ov[0]), .OVF(ovf[0])
  );
  macc_pipe #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(16), .SIGNED(1), .MUL_STAGES(3)) u_dut1 (
    .CLK(CLK), .RST(RST), .CE(ce[1]), .IN_VALID(iv[1]), .A(a1), .B(b1),
    .CARRYIN(cin[1]), .ACC(acc[1]), .P(p1), .OUT_VALID(ov[1]), .OVF(ovf[1])
  );
  macc_pipe #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(16), .SIGNED(0), .MUL_STAGES(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .CE(ce[2]), .IN_VALID(iv[2]), .A(a2), .B(b2),
    .CARRYIN(cin[2]), .ACC(acc[2]), .P(p2), .OUT_VALID(ov[2]), .OVF(ovf[2])
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, got, exp);
    end
  endtask

  function automatic longint mk(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint sx(input longint x, input int w);
    longint y;
    y = x & mk(w);
    if (y[w-1]) y = y - (longint'(1) << w);
    return y;
  endfunction

  function automatic logic [63:0] dut_p(input int d);
    case (d)
      0:       return 64'(p0);
      1:       return 64'(p1);
      default: return 64'(p2);
    endcase
  endfunction

  // Model: each beat's result is computed at issue from the running result of all
  // earlier beats, then released after LAT enabled cycles.
  longint run_p [3];
  bit     run_ovf [3];
  bit     lv [3][4];
  longint lp [3][4];
  bit     lo [3][4];
  longint m_p [3];
  bit     m_ov [3];
  bit     m_ovf [3];
  bit     upd [3];
  bit     chk_en = 1'b0;
  longint log_p [$];
  bit     log_o [$];

  always @(posedge CLK) begin
    for (int d = 0; d < 3; d++) begin
      longint a, b, av, bv, pv, sum;
      bit ob, nv, no;
      longint np;
      upd[d] = 1'b0;
      if (RST === 1'b0) begin
        run_p[d] = 0; run_ovf[d] = 1'b0;
        m_p[d] = 0; m_ov[d] = 1'b0; m_ovf[d] = 1'b0;
        for (int k = 0; k < 4; k++) begin
          lv[d][k] = 1'b0; lp[d][k] = 0; lo[d][k] = 1'b0;
        end
      end else if (ce[d] === 1'b1) begin
        upd[d] = 1'b1;
        case (d)
          0:       begin a = longint'(a0); b = longint'(b0); end
          1:       begin a = longint'(a1); b = longint'(b1); end
          default: begin a = longint'(a2); b = longint'(b2); end
        endcase
        if (iv[d] === 1'b1) begin
          av  = (SG[d] != 0) ? sx(a, AW[d]) : (a & mk(AW[d]));
          bv  = (SG[d] != 0) ? sx(b, BW[d]) : (b & mk(BW[d]));
          pv  = (SG[d] != 0) ? sx(run_p[d], PW[d]) : run_p[d];
          sum = ((acc[d] === 1'b1) ? pv : 0) + av * bv + longint'(cin[d]);
          if (SG[d] != 0)
            ob = (sum > mk(PW[d]-1)) || (sum < -(longint'(1) << (PW[d]-1)));
          else
            ob = sum > mk(PW[d]);
          run_p[d]   = sum & mk(PW[d]);
          run_ovf[d] = (acc[d] === 1'b1) ? (run_ovf[d] | ob) : 1'b0;
        end
        nv = lv[d][LAT[d]-1]; np = lp[d][LAT[d]-1]; no = lo[d][LAT[d]-1];
        for (int k = 3; k > 0; k--) begin
          lv[d][k] = lv[d][k-1]; lp[d][k] = lp[d][k-1]; lo[d][k] = lo[d][k-1];
        end
        lv[d][0] = (iv[d] === 1'b1); lp[d][0] = run_p[d]; lo[d][0] = run_ovf[d];
        m_ov[d] = nv;
        if (nv) begin
          m_p[d] = np; m_ovf[d] = no;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("model_p%0d", d), dut_p(d), 64'(m_p[d]));
        check($sformatf("model_valid%0d", d), 64'(ov[d]), 64'(m_ov[d]));
        check($sformatf("model_ovf%0d", d), 64'(ovf[d]), 64'(m_ovf[d]));
        if (upd[d] && ov[d] === 1'b1) begin
          log_p.push_back(longint'(dut_p(d)));
          log_o.push_back(ovf[d]);
        end
      end
    end
  end

  task automatic drive(input int d, input longint a, input longint b, input bit ci, input bit ac);
    iv[d] = 1'b1; cin[d] = ci; acc[d] = ac;
    case (d)
      0:       begin a0 = a[24:0]; b0 = b[17:0]; end
      1:       begin a1 = a[7:0];  b1 = b[7:0];  end
      default: begin a2 = a[7:0];  b2 = b[7:0];  end
    endcase
    @(negedge CLK);
    $display("beat dut%0d a=%0d b=%0d cin=%0d acc=%0d", d, a, b, ci, ac);
  endtask

  task automatic idle(input int n);
    for (int d = 0; d < 3; d++) iv[d] = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST = 1'b0;
    for (int d = 0; d < 3; d++) begin
      ce[d] = 1'b1; iv[d] = 1'b0; cin[d] = 1'b0; acc[d] = 1'b0;
    end
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (3) @(negedge CLK);
    chk_en = 1'b1;
    check("reset_p0", 64'(p0), 64'd0);
    check("reset_valid0", 64'(ov[0]), 64'd0);
    check("reset_ovf0", 64'(ovf[0]), 64'd0);
    check("reset_p1", 64'(p1), 64'd0);
    RST = 1'b1;

    // Single load 3*5+1, two cycles of latency.
    drive(0, 3, 5, 1'b1, 1'b0);
    check("load_early_valid", 64'(ov[0]), 64'd0);
    idle(1);
    check("load_mid_valid", 64'(ov[0]), 64'd0);
    idle(1);
    check("load_valid", 64'(ov[0]), 64'd1);
    check("load_p", 64'(p0), 64'd16);
    idle(1);
    check("load_after_valid", 64'(ov[0]), 64'd0);
    check("load_hold_p", 64'(p0), 64'd16);

    // Accumulate stream 4, 14, 24, 34.
    log_p.delete(); log_o.delete();
    drive(0, 2, 2, 1'b0, 1'b0);
    repeat (3) drive(0, 1, 10, 1'b0, 1'b1);
    idle(5);
    check("stream_count", 64'(log_p.size()), 64'd4);
    check("stream_p0", 64'(log_p[0]), 64'd4);
    check("stream_p1", 64'(log_p[1]), 64'd14);
    check("stream_p2", 64'(log_p[2]), 64'd24);
    check("stream_p3", 64'(log_p[3]), 64'd34);

    // Signed: -21, then +16384 three times; only the third sum leaves 16-bit range.
    log_p.delete(); log_o.delete();
    drive(1, -3, 7, 1'b0, 1'b0);
    repeat (3) drive(1, -128, -128, 1'b0, 1'b1);
    idle(7);
    check("signed_count", 64'(log_p.size()), 64'd4);
    check("signed_p0", 64'(log_p[0]), 64'hFFEB);
    check("signed_p1", 64'(log_p[1]), 64'd16363);
    check("signed_p2", 64'(log_p[2]), 64'd32747);
    check("signed_p3", 64'(log_p[3]), 64'hBFEB);
    check("signed_ovf2", 64'(log_o[2]), 64'd0);
    check("signed_ovf3", 64'(log_o[3]), 64'd1);

    // Unsigned: 65025, +510 -> 65535, +1 -> wraps to 0 with overflow.
    log_p.delete(); log_o.delete();
    drive(2, 255, 255, 1'b0, 1'b0);
    drive(2, 255, 2, 1'b0, 1'b1);
    drive(2, 1, 1, 1'b0, 1'b1);
    idle(6);
    check("uns_count", 64'(log_p.size()), 64'd3);
    check("uns_p0", 64'(log_p[0]), 64'd65025);
    check("uns_p1", 64'(log_p[1]), 64'd65535);
    check("uns_ovf1", 64'(log_o[1]), 64'd0);
    check("uns_p2", 64'(log_p[2]), 64'd0);
    check("uns_ovf2", 64'(log_o[2]), 64'd1);
    idle(5);
    check("uns_ovf_sticky", 64'(ovf[2]), 64'd1);
    drive(2, 1, 1, 1'b0, 1'b0);
    idle(5);
    check("uns_ovf_cleared", 64'(ovf[2]), 64'd0);
    check("uns_reload_p", 64'(p2), 64'd1);

    // CE stall with three beats in flight.
    log_p.delete(); log_o.delete();
    drive(0, 1, 7, 1'b0, 1'b0);
    drive(0, 2, 3, 1'b0, 1'b1);
    drive(0, 1, 1, 1'b1, 1'b1);
    iv[0] = 1'b0;
    ce[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_p", 64'(p0), 64'd7);
      check("stall_valid", 64'(ov[0]), 64'd1);
    end
    ce[0] = 1'b1;
    idle(5);
    check("stall_count", 64'(log_p.size()), 64'd3);
    check("stall_p0", 64'(log_p[0]), 64'd7);
    check("stall_p1", 64'(log_p[1]), 64'd13);
    check("stall_p2", 64'(log_p[2]), 64'd15);

    // Reset with CE low while two beats are in flight.
    log_p.delete(); log_o.delete();
    drive(0, 5, 5, 1'b0, 1'b0);
    drive(0, 1, 1, 1'b0, 1'b1);
    RST = 1'b0; ce[0] = 1'b0; iv[0] = 1'b0;
    @(negedge CLK);
    RST = 1'b1; ce[0] = 1'b1;
    idle(6);
    check("rst_p", 64'(p0), 64'd0);
    check("rst_ovf", 64'(ovf[0]), 64'd0);
    check("rst_valid", 64'(ov[0]), 64'd0);
    check("rst_no_pulse", 64'(log_p.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
